// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: widths, execute command
// encodings and the packed control bundle carried between stages.
package arm_pkg;

  localparam int CMD_W   = 4;
  localparam int REG_W   = 4;
  localparam int SHIFT_W = 12;

  // Execute-stage ALU command encodings
  localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;
  localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
  localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;

  typedef struct packed {
    logic             wb_en;
    logic             mem_r;
    logic             mem_w;
    logic             b;
    logic             s;
    logic [CMD_W-1:0] exe_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async reset, synchronous clear,
// hold, otherwise load. Clear takes priority over hold.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Field storage with clear > hold > load priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (clear) q <= '0;
    else if (!hold) q <= d;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. Squashed or condition-failed instructions
// become all-zero bubbles; the hazard unit can freeze the slot; a
// saturating debug counter tracks how many real instructions were squashed.
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = arm_pkg::REG_W,
  parameter int CMD_W   = arm_pkg::CMD_W,
  parameter int SHIFT_W = arm_pkg::SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               cond_ok,
  input  logic               id_valid,
  input  logic               id_wb_en,
  input  logic               id_mem_r,
  input  logic               id_mem_w,
  input  logic               id_b,
  input  logic               id_s,
  input  logic               id_imm,
  input  logic [CMD_W-1:0]   id_exe_cmd,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  id_val_rn,
  input  logic [DATA_W-1:0]  id_val_rm,
  input  logic [SHIFT_W-1:0] id_shift_op,
  input  logic [23:0]        id_imm24,
  input  logic [REG_W-1:0]   id_dest,
  input  logic [REG_W-1:0]   id_src1,
  input  logic [REG_W-1:0]   id_src2,
  input  logic [3:0]         id_status,
  output logic               ex_valid,
  output logic               ex_wb_en,
  output logic               ex_mem_r,
  output logic               ex_mem_w,
  output logic               ex_b,
  output logic               ex_s,
  output logic               ex_imm,
  output logic [CMD_W-1:0]   ex_exe_cmd,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_val_rn,
  output logic [DATA_W-1:0]  ex_val_rm,
  output logic [SHIFT_W-1:0] ex_shift_op,
  output logic [23:0]        ex_imm24,
  output logic [REG_W-1:0]   ex_dest,
  output logic [REG_W-1:0]   ex_src1,
  output logic [REG_W-1:0]   ex_src2,
  output logic [3:0]         ex_status,
  output logic [15:0]        bubble_cnt
);

  import arm_pkg::*;

  localparam int DW = 3*DATA_W + SHIFT_W + 24 + 3*REG_W + 4 + 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic          live;
  logic          clear;
  logic          squash;
  ctrl_t         ctrl_d;
  ctrl_t         ctrl_q;
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;

  assign live  = id_valid & cond_ok;
  // A frozen slot keeps its contents even if ID now holds a failing
  // instruction; only flush may break through a freeze.
  assign clear = flush | (~freeze & ~live);
  // Real instructions lost this edge (empty slots are not counted)
  assign squash = id_valid & (flush | (~freeze & ~cond_ok));

  assign ctrl_d = '{wb_en:   id_wb_en,
                    mem_r:   id_mem_r,
                    mem_w:   id_mem_w,
                    b:       id_b,
                    s:       id_s,
                    exe_cmd: id_exe_cmd};

  assign data_d = {id_pc, id_val_rn, id_val_rm, id_shift_op, id_imm24,
                   id_dest, id_src1, id_src2, id_status, id_imm};

  pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .hold  (freeze),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_field_reg #(.W(DW)) u_data_reg (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .hold  (freeze),
    .d     (data_d),
    .q     (data_q)
  );

  // Valid bit follows the same clear/hold/load policy as the bundles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ex_valid <= 1'b0;
    else if (clear)  ex_valid <= 1'b0;
    else if (!freeze) ex_valid <= 1'b1;
  end

  // Saturating count of squashed real instructions
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bubble_cnt <= '0;
    else if (squash) bubble_cnt <= sat_inc(bubble_cnt);
  end

  assign ex_wb_en   = ctrl_q.wb_en;
  assign ex_mem_r   = ctrl_q.mem_r;
  assign ex_mem_w   = ctrl_q.mem_w;
  assign ex_b       = ctrl_q.b;
  assign ex_s       = ctrl_q.s;
  assign ex_exe_cmd = ctrl_q.exe_cmd;

  assign {ex_pc, ex_val_rn, ex_val_rm, ex_shift_op, ex_imm24,
          ex_dest, ex_src1, ex_src2, ex_status, ex_imm} = data_q;

endmodule
